// File: rtl/tristate_sel_pkg.sv
// Shared types and helpers for the tristate select sequencer.
package tristate_sel_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Width of the break-before-make gap counter (GAP_CYCLES up to 255).
    localparam int unsigned GapCntW = 8;

    // Largest select width the helpers support; callers truncate to 2**SEL_W.
    localparam int unsigned MaxSelW = 8;
    localparam int unsigned MaxCh   = 2 ** MaxSelW;

    // One-hot encode a channel index into the widest supported vector.
    function automatic logic [MaxCh-1:0] onehot(input logic [MaxSelW-1:0] sel);
        logic [MaxCh-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational N-to-2^N decoder with enable; all outputs low when disabled.
module onehot_decoder
    import tristate_sel_pkg::*;
#(
    parameter int unsigned SEL_W = 2
) (
    input  logic               en,
    input  logic [SEL_W-1:0]   sel,
    output logic [2**SEL_W-1:0] dec
);

    localparam int unsigned NCh = 2 ** SEL_W;

    logic [MaxCh-1:0] full_vec;

    // Decode against the widest vector, then keep only this instance's channels.
    always_comb begin
        full_vec = onehot(MaxSelW'(sel));
        dec      = en ? NCh'(full_vec) : '0;
    end

endmodule

// File: rtl/tristate_select_sequencer.sv
// Registered one-hot output-enable sequencer with break-before-make gap on
// every channel change, so no two tristate drivers are ever on together.
module tristate_select_sequencer
    import tristate_sel_pkg::*;
#(
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    output logic                sel_ready,
    output logic [2**SEL_W-1:0] oe,
    output logic [SEL_W-1:0]    cur_sel,
    output logic                busy,
    output logic [CNT_W-1:0]    switch_cnt
);

    localparam int unsigned NCh = 2 ** SEL_W;

    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_gap_range_check
        $error("GAP_CYCLES must be in 1..255");
    end
    if (SEL_W < 1 || SEL_W > MaxSelW) begin : g_sel_w_check
        $error("SEL_W must be in 1..8");
    end

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [GapCntW-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   switch_cnt_q, switch_cnt_d;
    logic [NCh-1:0]     oe_q, oe_d;
    logic               busy_q, busy_d;
    logic               accept;

    assign sel_ready = en && (state_q != GAP);
    assign accept    = sel_valid && sel_ready;

    // Next-state logic: select tracking, gap countdown and switch counting.
    always_comb begin
        state_d      = state_q;
        cur_sel_d    = cur_sel_q;
        gap_cnt_d    = gap_cnt_q;
        switch_cnt_d = switch_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cur_sel_d = sel;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (accept && (sel != cur_sel_q)) begin
                    cur_sel_d = sel;
                    gap_cnt_d = GapCntW'(GAP_CYCLES);
                    state_d   = GAP;
                end
            end
            GAP: begin
                // Abandoning a gap keeps the pending select but is not a switch.
                if (!en) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q <= GapCntW'(1)) begin
                    state_d   = DRIVE;
                    gap_cnt_d = '0;
                    if (switch_cnt_q != '1) begin
                        switch_cnt_d = switch_cnt_q + CNT_W'(1);
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GapCntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == GAP);
    end

    // The enable vector is decoded from next-state so oe is a clean register.
    onehot_decoder #(
        .SEL_W (SEL_W)
    ) u_onehot_decoder (
        .en  (state_d == DRIVE),
        .sel (cur_sel_d),
        .dec (oe_d)
    );

    // State registers; reset clears the enables without waiting for a gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_sel_q    <= '0;
            gap_cnt_q    <= '0;
            switch_cnt_q <= '0;
            oe_q         <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_sel_q    <= cur_sel_d;
            gap_cnt_q    <= gap_cnt_d;
            switch_cnt_q <= switch_cnt_d;
            oe_q         <= oe_d;
            busy_q       <= busy_d;
        end
    end

    assign oe         = oe_q;
    assign cur_sel    = cur_sel_q;
    assign busy       = busy_q;
    assign switch_cnt = switch_cnt_q;

endmodule

// File: tb/tb_tristate_select_sequencer.sv
// Directed bench for tristate_select_sequencer: three instances cover the
// main sequencing (SEL_W=2, gap 3), a randomised exclusivity run (SEL_W=3)
// and switch counter saturation (CNT_W=4).
module tb_tristate_select_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: SEL_W=2, GAP_CYCLES=3, CNT_W=16.
    logic        rst_a, en_a, valid_a, ready_a, busy_a;
    logic [1:0]  sel_a, cur_a;
    logic [3:0]  oe_a;
    logic [15:0] cnt_a;

    // Instance R: SEL_W=3, GAP_CYCLES=2, CNT_W=16.
    logic        rst_r, en_r, valid_r, ready_r, busy_r;
    logic [2:0]  sel_r, cur_r;
    logic [7:0]  oe_r;
    logic [15:0] cnt_r;

    // Instance S: SEL_W=2, GAP_CYCLES=1, CNT_W=4.
    logic        rst_s, en_s, valid_s, ready_s, busy_s;
    logic [1:0]  sel_s, cur_s;
    logic [3:0]  oe_s;
    logic [3:0]  cnt_s;

    tristate_select_sequencer #(.SEL_W(2), .GAP_CYCLES(3), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .sel_valid(valid_a), .sel(sel_a),
        .sel_ready(ready_a), .oe(oe_a), .cur_sel(cur_a), .busy(busy_a), .switch_cnt(cnt_a)
    );

    tristate_select_sequencer #(.SEL_W(3), .GAP_CYCLES(2), .CNT_W(16)) u_dut_r (
        .clk(clk), .rst(rst_r), .en(en_r), .sel_valid(valid_r), .sel(sel_r),
        .sel_ready(ready_r), .oe(oe_r), .cur_sel(cur_r), .busy(busy_r), .switch_cnt(cnt_r)
    );

    tristate_select_sequencer #(.SEL_W(2), .GAP_CYCLES(1), .CNT_W(4)) u_dut_s (
        .clk(clk), .rst(rst_s), .en(en_s), .sel_valid(valid_s), .sel(sel_s),
        .sel_ready(ready_s), .oe(oe_s), .cur_sel(cur_s), .busy(busy_s), .switch_cnt(cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns on the falling edge, away from the active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; valid_a = 1'b0; sel_a = 2'd0;
        rst_r = 1'b1; en_r = 1'b0; valid_r = 1'b0; sel_r = 3'd0;
        rst_s = 1'b1; en_s = 1'b0; valid_s = 1'b0; sel_s = 2'd0;
        tick();
        tick();
        check("rst_oe_held", 32'(oe_a), 32'h0);
        rst_a = 1'b0; rst_r = 1'b0; rst_s = 1'b0;
        #1;

        // Reset state.
        check("reset_oe", 32'(oe_a), 32'h0);
        check("reset_cur_sel", 32'(cur_a), 32'h0);
        check("reset_busy", 32'(busy_a), 32'h0);
        check("reset_cnt", 32'(cnt_a), 32'h0);
        check("ready_en_low", 32'(ready_a), 32'h0);
        en_a = 1'b1;
        #1;
        check("ready_en_high", 32'(ready_a), 32'h1);

        // IDLE accept: one edge of latency.
        valid_a = 1'b1; sel_a = 2'd2;
        tick();
        valid_a = 1'b0;
        check("idle_accept_oe", 32'(oe_a), 32'h4);
        check("idle_accept_cnt", 32'(cnt_a), 32'h0);
        check("idle_accept_cur", 32'(cur_a), 32'h2);

        // Switch 2 -> 1 with a three-cycle gap.
        valid_a = 1'b1; sel_a = 2'd1;
        tick();
        valid_a = 1'b0;
        check("gap_cur_sel", 32'(cur_a), 32'h1);
        for (int i = 0; i < 3; i++) begin
            check("gap_oe_off", 32'(oe_a), 32'h0);
            check("gap_busy", 32'(busy_a), 32'h1);
            check("gap_ready_low", 32'(ready_a), 32'h0);
            tick();
        end
        check("after_gap_oe", 32'(oe_a), 32'h2);
        check("after_gap_busy", 32'(busy_a), 32'h0);
        check("after_gap_cnt", 32'(cnt_a), 32'h1);

        // Same-channel request: no glitch, no count.
        valid_a = 1'b1; sel_a = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("same_ch_oe", 32'(oe_a), 32'h2);
        end
        valid_a = 1'b0;
        check("same_ch_cnt", 32'(cnt_a), 32'h1);

        // en dropped during a gap: back to IDLE with the pending select kept.
        valid_a = 1'b1; sel_a = 2'd0;
        tick();
        valid_a = 1'b0;
        check("gap2_busy", 32'(busy_a), 32'h1);
        en_a = 1'b0;
        tick();
        check("abort_oe", 32'(oe_a), 32'h0);
        check("abort_busy", 32'(busy_a), 32'h0);
        check("abort_cur_sel", 32'(cur_a), 32'h0);
        check("abort_cnt", 32'(cnt_a), 32'h1);
        tick();
        check("abort_oe_stays", 32'(oe_a), 32'h0);
        en_a = 1'b1; valid_a = 1'b1; sel_a = 2'd3;
        #1;
        check("reenable_ready", 32'(ready_a), 32'h1);
        tick();
        valid_a = 1'b0;
        check("reenable_oe", 32'(oe_a), 32'h8);
        check("reenable_cnt", 32'(cnt_a), 32'h1);

        // en falling while driving, then en low with a request: request ignored.
        en_a = 1'b0;
        tick();
        check("en_fall_oe", 32'(oe_a), 32'h0);
        valid_a = 1'b1; sel_a = 2'd2;
        #1;
        check("en_low_ready", 32'(ready_a), 32'h0);
        tick();
        valid_a = 1'b0;
        check("en_low_req_oe", 32'(oe_a), 32'h0);

        // Async reset mid-DRIVE, between edges.
        en_a = 1'b1; valid_a = 1'b1; sel_a = 2'd3;
        tick();
        valid_a = 1'b0;
        check("pre_rst_oe", 32'(oe_a), 32'h8);
        #2;
        rst_a = 1'b1;
        #1;
        check("async_rst_oe", 32'(oe_a), 32'h0);
        check("async_rst_cnt", 32'(cnt_a), 32'h0);
        check("async_rst_cur", 32'(cur_a), 32'h0);
        @(negedge clk);
        rst_a = 1'b0;
        tick();
        check("post_rst_oe", 32'(oe_a), 32'h0);

        // Random run on the SEL_W=3 instance: at most one enable, matching cur_sel.
        for (int i = 0; i < 10000; i++) begin
            en_r    = ($urandom_range(0, 15) != 0);
            valid_r = 1'($urandom_range(0, 1));
            sel_r   = 3'($urandom_range(0, 7));
            if (i % 2500 == 1234) begin
                #2;
                rst_r = 1'b1;
                #1;
                check("rand_rst_oe", 32'(oe_r), 32'h0);
                @(negedge clk);
                rst_r = 1'b0;
            end
            tick();
            check("rand_popcount", 32'($countones(oe_r) <= 1), 32'h1);
            check("rand_oe_cur", 32'(oe_r), (oe_r == 8'h0) ? 32'h0 : (32'h1 << cur_r));
        end

        // Saturation on the CNT_W=4 instance: 20 switches clamp at 15.
        en_s = 1'b1; valid_s = 1'b1; sel_s = 2'd0;
        tick();
        valid_s = 1'b0;
        check("sat_first_oe", 32'(oe_s), 32'h1);
        for (int i = 0; i < 20; i++) begin
            valid_s = 1'b1;
            sel_s   = (i % 2 == 0) ? 2'd1 : 2'd0;
            tick();
            valid_s = 1'b0;
            tick();
            check("sat_cnt", 32'(cnt_s), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        check("sat_final_oe", 32'(oe_s), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tristate_select_sequencer.md
# tristate_select_sequencer

Parametrised, registered select decoder for the shared tristate bus. It turns an SEL_W-bit channel select into a one-hot, registered output-enable vector, one bit per tristate driver. On every change of the active channel it inserts a programmable break-before-make gap with all enables low, so two drivers are never on the bus together. It sits between the bus controller, which issues select requests, and the per-channel tristate buffers of the decoder-based mux datapath.

## Interface
- SEL_W, 2, select width; channel count N_CH = 2**SEL_W (derived, not overridable)
- GAP_CYCLES, 1, number of all-off cycles inserted on a channel change; legal range 1..255
- CNT_W, 16, width of the switch counter
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  global enable; low forces all drivers off
- sel_valid  input  1  select request valid
- sel  input  SEL_W  requested channel
- sel_ready  output  1  request accepted when sel_valid && sel_ready
- oe  output  N_CH  registered one-hot output enables; oe[i] drives tristate buffer i
- cur_sel  output  SEL_W  registered channel currently driven, or pending during GAP
- busy  output  1  high while in GAP
- switch_cnt  output  CNT_W  completed channel changes, saturating

## Operation
- Reset values: state IDLE, oe=0, cur_sel=0, busy=0, switch_cnt=0, internal gap counter 0.
- sel_ready is combinational: sel_ready = en && (state != GAP).
- The FSM has three states:
  - IDLE: oe=0.
    - Accept → cur_sel<=sel, go to DRIVE.
  - DRIVE: oe=onehot(cur_sel).
    - Accept with sel==cur_sel → no change.
    - Accept with sel!=cur_sel → cur_sel<=sel, gap counter<=GAP_CYCLES, busy<=1, oe<=0, go to GAP.
    - en low → go to IDLE with oe<=0.
  - GAP: oe=0.
    - Gap counter decrements each cycle.
    - When the counter reaches 1 → go to DRIVE, oe<=onehot(cur_sel), busy<=0, switch_cnt++.
    - en low in GAP → go to IDLE, busy<=0, pending select kept in cur_sel, no count.
- Invariant: popcount(oe) ≤ 1 in every cycle, including reset and reset release.
- switch_cnt saturates at 2**CNT_W-1. An IDLE→DRIVE transition is not a switch.
- sel_valid without sel_ready: the request is ignored. It is not queued, and the bus controller must hold it.
- An out-of-range GAP_CYCLES is rejected at elaboration (simulation $error / synthesis assertion).
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously); oe drops without waiting for a gap.

## Timing
- All outputs except sel_ready are registered.
- IDLE accept at edge k: oe one-hot from edge k onward (latency 1).
- Switch accepted at edge k: oe=0 from edge k. New oe asserted at edge k+GAP_CYCLES, giving exactly GAP_CYCLES full cycles of all-off.
- Same-channel request while in DRIVE: oe unchanged, with no glitch cycle.
- en falling, sampled at edge k: oe=0 from edge k.
- Simultaneous en low and sel_valid: sel_ready=0, so the request is not accepted and en takes priority.
- Gap countdown and switch_cnt increment happen on the same edge that re-enters DRIVE.

## Structure
- Package tristate_sel_pkg contains:
  - state enum {IDLE, DRIVE, GAP}
  - gap counter width constant (8 bits)
  - function onehot(sel) returning a 2**SEL_W vector
- One sub-module, onehot_decoder #(SEL_W): purely combinational N-to-2^N decoder with enable. It is the generalised form of the team's 2-to-4 decoder and is instantiated once to form the next-state oe value.
- Top level: FSM, gap counter, cur_sel register, switch counter.

## Test plan
- Reset release, SEL_W=2: oe=0000, sel_ready=1 with en=1. Request sel=2 → oe=0100 after one edge, switch_cnt=0.
- Switch 2→1 with GAP_CYCLES=3: oe=0000 for exactly 3 cycles, busy=1 and sel_ready=0 during the gap. Then oe=0010, busy=0, switch_cnt=1.
- Request sel=1 while driving channel 1: oe stays 0010 with no zero cycle, switch_cnt unchanged.
- en low during GAP: oe stays 0000, state goes to IDLE, busy=0. Re-enable and request sel=3 → oe=1000 after one edge.
- Async rst pulse mid-DRIVE, between clock edges: oe=0 immediately, switch_cnt=0. Across a random run of 10k requests with SEL_W=3, assert popcount(oe)≤1 every cycle.
- CNT_W=4, 20 switches: switch_cnt saturates at 15.
